// File: rtl/zx_pager.sv
// Paging unit for the 48K/128K/+2A family: holds the 7FFD/1FFD registers and maps
// CPU and video addresses onto the external SRAM, gating writes to ROM pages.
module zx_pager #(
    parameter int MODE      = 1,
    parameter int RAM_BANKS = 8,
    parameter int AW        = 21,
    parameter int RAM_BASE  = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iorq,
    input  logic          mreq,
    input  logic          wr,
    input  logic [15:0]   cpuA,
    input  logic [7:0]    cpuDi,
    input  logic [12:0]   vmmA,
    output logic [AW-1:0] ramA,
    output logic          ramWe,
    output logic          romCs,
    output logic [AW-1:0] vmmRamA,
    output logic          locked,
    output logic [7:0]    p7ffd,
    output logic [7:0]    p1ffd
);
    localparam int PW = AW - 14;

    logic [7:0]    reg_7ffd;
    logic [7:0]    reg_1ffd;
    logic          lock_q;
    logic          history;
    logic          ios;
    logic          fire;
    logic          sel_7ffd;
    logic          sel_1ffd;
    logic [4:0]    bank_b;
    logic [4:0]    cpu_bank;
    logic [4:0]    video_bank;
    logic [1:0]    rom_sel;
    logic          is_rom;
    logic          special;
    logic [PW-1:0] cpu_page;
    logic [PW-1:0] video_page;

    // History starts at 1 so a strobe already asserted when reset drops is not taken as a new write.
    always_comb begin
        ios      = !iorq && !wr;
        fire     = ios && !history;
        sel_7ffd = 1'b0;
        sel_1ffd = 1'b0;
        if (MODE == 1) begin
            sel_7ffd = !cpuA[15] && !cpuA[1];
        end else if (MODE == 2) begin
            sel_7ffd = (cpuA[15:14] == 2'b01) && !cpuA[1];
            sel_1ffd = (cpuA[15:12] == 4'b0001) && !cpuA[1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_7ffd <= 8'h00;
            reg_1ffd <= 8'h00;
            lock_q   <= 1'b0;
            history  <= 1'b1;
        end else begin
            history <= ios;
            if (fire && !lock_q) begin
                if (sel_7ffd) begin
                    reg_7ffd <= cpuDi;
                    lock_q   <= cpuDi[5];
                end
                if (sel_1ffd) begin
                    reg_1ffd <= cpuDi;
                end
            end
        end
    end

    always_comb begin
        bank_b  = 5'd0;
        rom_sel = 2'd0;
        if (MODE != 0) begin
            bank_b[2:0] = reg_7ffd[2:0];
            if (RAM_BANKS >= 16) bank_b[3] = reg_7ffd[6];
            if (RAM_BANKS >= 32) bank_b[4] = reg_7ffd[7];
        end
        if (MODE == 1) rom_sel = {1'b0, reg_7ffd[4]};
        else if (MODE == 2) rom_sel = {reg_1ffd[2], reg_7ffd[4]};
        special = (MODE == 2) && reg_1ffd[0];
    end

    // Special (all-RAM) layouts come from 1FFD[2:1]; otherwise slot 0 is ROM.
    always_comb begin
        is_rom   = 1'b0;
        cpu_bank = 5'd0;
        if (special) begin
            case ({reg_1ffd[2:1], cpuA[15:14]})
                4'b00_00: cpu_bank = 5'd0;
                4'b00_01: cpu_bank = 5'd1;
                4'b00_10: cpu_bank = 5'd2;
                4'b00_11: cpu_bank = 5'd3;
                4'b01_00: cpu_bank = 5'd4;
                4'b01_01: cpu_bank = 5'd5;
                4'b01_10: cpu_bank = 5'd6;
                4'b01_11: cpu_bank = 5'd7;
                4'b10_00: cpu_bank = 5'd4;
                4'b10_01: cpu_bank = 5'd5;
                4'b10_10: cpu_bank = 5'd6;
                4'b10_11: cpu_bank = 5'd3;
                4'b11_00: cpu_bank = 5'd4;
                4'b11_01: cpu_bank = 5'd7;
                4'b11_10: cpu_bank = 5'd6;
                default:  cpu_bank = 5'd3;
            endcase
        end else begin
            case (cpuA[15:14])
                2'b00:   is_rom   = 1'b1;
                2'b01:   cpu_bank = 5'd5;
                2'b10:   cpu_bank = 5'd2;
                default: cpu_bank = bank_b;
            endcase
        end
        cpu_page   = is_rom ? PW'(rom_sel) : PW'(RAM_BASE + int'(cpu_bank));
        video_bank = ((MODE != 0) && reg_7ffd[3]) ? 5'd7 : 5'd5;
        video_page = PW'(RAM_BASE + int'(video_bank));
    end

    assign ramA    = {cpu_page, cpuA[13:0]};
    assign romCs   = is_rom;
    assign ramWe   = !(!mreq && !wr && !is_rom);
    assign vmmRamA = {video_page, 1'b0, vmmA};
    assign locked  = lock_q;
    assign p7ffd   = reg_7ffd;
    assign p1ffd   = reg_1ffd;
endmodule
